// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the state encoding, the requester count and the winner-pick function.
package mux_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } rr_pick_t;

  // The scan runs from the far end back toward ptr, so the last hit is the closest one.
  function automatic rr_pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SELW-1:0] ptr);
    rr_pick_t        res;
    logic [SELW-1:0] cand;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SELW'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bus of the shared mux: requests and data in, grant, select and sample out.
// master = requester front-ends, slave = arbiter.
interface mux_rr_arbiter_if
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DW = 1
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    grant;
  logic [SELW-1:0]    select;
  logic [DW-1:0]      dout;
  logic               valid;

  modport master (output req, din, input grant, select, dout, valid);
  modport slave  (input req, din, output grant, select, dout, valid);
endinterface

// File: rtl/mux_rr_arbiter_mux.sv
// Existing single-bit 4:1 mux shared by the requesters.
module mux_rr_arbiter_mux
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_d,
  input  logic [SELW-1:0] i_sel,
  output logic            o_y
);
  assign o_y = i_d[i_sel];
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the shared 4:1 mux; grants are capped at MAX_HOLD samples.
// The selected data is registered into dout with a valid strobe.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
)(
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_arbiter_if.slave bus
);
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [SELW-1:0] r_select, w_select_nxt;
  logic [DW-1:0]   r_dout, w_dout_nxt;
  logic            r_valid, w_valid_nxt;
  logic [SELW-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]      r_hold_cnt, w_hold_nxt;

  logic [DW-1:0]   w_mux;
  logic [7:0]      w_hold_inc;
  logic [SELW-1:0] w_ptr_after;
  rr_pick_t        w_pick_idle, w_pick_end;

  for (genvar b = 0; b < DW; b++) begin : g_bit
    logic [NREQ-1:0] w_bits;
    always_comb begin
      w_bits = '0;
      for (int i = 0; i < NREQ; i++) w_bits[i] = bus.din[i*DW + b];
    end
    mux_rr_arbiter_mux u_mux (
      .i_d   (w_bits),
      .i_sel (r_select),
      .o_y   (w_mux[b])
    );
  end

  assign w_hold_inc  = r_hold_cnt + 8'd1;
  assign w_ptr_after = r_select + SELW'(1);
  assign w_pick_idle = rr_pick(bus.req, r_ptr);
  assign w_pick_end  = rr_pick(bus.req, w_ptr_after);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_select   <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_select   <= w_select_nxt;
      r_dout     <= w_dout_nxt;
      r_valid    <= w_valid_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_comb begin
    logic end_grant;
    end_grant    = 1'b0;
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_select_nxt = r_select;
    w_dout_nxt   = r_dout;
    w_valid_nxt  = r_valid;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold_cnt;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_pick_idle.found) begin
          w_grant_nxt  = onehot(w_pick_idle.idx);
          w_select_nxt = w_pick_idle.idx;
          w_hold_nxt   = '0;
          w_state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (bus.req[r_select]) begin
          w_dout_nxt  = w_mux;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = w_hold_inc;
          end_grant   = (w_hold_inc == MAX_HOLD_C);
        end else begin
          w_valid_nxt = 1'b0;
          end_grant   = 1'b1;
        end
        // Re-arbitrate on the same edge so a handover costs no idle cycle.
        if (end_grant) begin
          w_ptr_nxt = w_ptr_after;
          if (w_pick_end.found) begin
            w_grant_nxt  = onehot(w_pick_end.idx);
            w_select_nxt = w_pick_end.idx;
            w_hold_nxt   = '0;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.grant  = r_grant;
    bus.select = r_select;
    bus.dout   = r_dout;
    bus.valid  = r_valid;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: dut_a uses MAX_HOLD=4 (table vectors), dut_b uses MAX_HOLD=1 (rotation).
module tb_mux_rr_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  mux_rr_arbiter_if #(.DW(1)) bus_a ();
  mux_rr_arbiter_if #(.DW(1)) bus_b ();

  mux_rr_arbiter #(.DW(1), .MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_rr_arbiter #(.DW(1), .MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    logic       d;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] din);
    bus_a.req = req; bus_a.din = din;
    bus_b.req = req; bus_b.din = din;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ".grant"}, 32'(bus_a.grant), 32'h0);
    chk({tag, ".select"}, 32'(bus_a.select), 32'h0);
    chk({tag, ".dout"}, 32'(bus_a.dout), 32'h0);
    chk({tag, ".valid"}, 32'(bus_a.valid), 32'h0);
  endtask

  initial begin
    tbl[0]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[4]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[6]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[7]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[9]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[10] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[11] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
    tbl[12] = '{4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[13] = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[15] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0};
    tbl[16] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[17] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[18] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[19] = '{4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[20] = '{4'b1001, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[21] = '{4'b1101, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[22] = '{4'b0011, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[23] = '{4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[24] = '{4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};

    // Reset held with every requester active.
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111);
    #1 rst_n = 1'b0;
    step();
    step();
    chk_zero_a("rst_a");
    chk("rst_b.grant", 32'(bus_b.grant), 32'h0);
    chk("rst_b.valid", 32'(bus_b.valid), 32'h0);
    rst_n = 1'b1;
    step();
    chk("first.grant", 32'(bus_a.grant), 32'h1);
    chk("first.select", 32'(bus_a.select), 32'h0);
    chk("first.valid", 32'(bus_a.valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold0.valid", 32'(bus_a.valid), 32'h1);
      chk("hold0.grant", 32'(bus_a.grant), 32'h1);
    end
    step();
    chk("rot01.grant", 32'(bus_a.grant), 32'h2);
    chk("rot01.select", 32'(bus_a.select), 32'h1);
    step();
    chk("g1.dout", 32'(bus_a.dout), 32'h1);

    // Async reset between edges, mid-grant.
    #2 rst_n = 1'b0;
    #1;
    chk_zero_a("async");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].req, tbl[i].din);
      step();
      chk($sformatf("v%0d.grant", i), 32'(bus_a.grant), 32'(tbl[i].g));
      chk($sformatf("v%0d.select", i), 32'(bus_a.select), 32'(tbl[i].s));
      chk($sformatf("v%0d.valid", i), 32'(bus_a.valid), 32'(tbl[i].v));
      chk($sformatf("v%0d.dout", i), 32'(bus_a.dout), 32'(tbl[i].d));
    end

    // MAX_HOLD=1 rotation with all requesters active.
    rst_n = 1'b0;
    drive(4'b1111, 4'b1010);
    step();
    rst_n = 1'b1;
    begin
      logic [1:0] exp_sel [5];
      logic       exp_d   [5];
      exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_d   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 1; k <= 6; k++) begin
        step();
        if (k <= 5) begin
          chk($sformatf("rr%0d.select", k), 32'(bus_b.select), 32'(exp_sel[k-1]));
          chk($sformatf("rr%0d.grant", k), 32'(bus_b.grant), 32'(4'b0001 << exp_sel[k-1]));
        end
        if (k >= 2) begin
          chk($sformatf("rr%0d.valid", k), 32'(bus_b.valid), 32'h1);
          chk($sformatf("rr%0d.dout", k), 32'(bus_b.dout), 32'(exp_d[k-2]));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
